// File: rtl/serial_subtractor_if.sv
// Handshake/result bundle between a requester and the bit-serial subtractor.
interface serial_subtractor_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] d;
    logic             b;

    // Requester drives operands and start, observes status and result.
    modport master (
        output start, x, y,
        input  busy, done, d, b
    );

    // Subtractor consumes operands and start, produces status and result.
    modport slave (
        input  start, x, y,
        output busy, done, d, b
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes x - y mod 2^WIDTH plus borrow, LSB first,
// one bit per clock. Result and borrow update only when an operation completes.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_subtractor_if.slave   bus
);

    // Counter must reach WIDTH without wrapping.
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] xs_q;
    logic [WIDTH-1:0] ys_q;
    logic [WIDTH-1:0] res_q;
    logic             borrow_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] d_q;
    logic             b_q;

    logic             diff_d;
    logic             borrow_d;
    logic [WIDTH-1:0] res_d;

    // Full subtractor on the current LSBs using the registered borrow.
    always_comb begin
        diff_d   = xs_q[0] ^ ys_q[0] ^ borrow_q;
        borrow_d = (~xs_q[0] & ys_q[0]) | (~(xs_q[0] ^ ys_q[0]) & borrow_q);
        res_d    = {diff_d, res_q[WIDTH-1:1]};
    end

    // Sequencer and datapath: accept, shift one bit per cycle, publish result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            xs_q     <= '0;
            ys_q     <= '0;
            res_q    <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            d_q      <= '0;
            b_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        xs_q     <= bus.x;
                        ys_q     <= bus.y;
                        res_q    <= '0;
                        borrow_q <= 1'b0;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= RUN;
                    end else begin
                        busy_q   <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                RUN: begin
                    xs_q     <= {1'b0, xs_q[WIDTH-1:1]};
                    ys_q     <= {1'b0, ys_q[WIDTH-1:1]};
                    res_q    <= res_d;
                    borrow_q <= borrow_d;
                    cnt_q    <= cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        d_q     <= res_d;
                        b_q     <= borrow_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.d    = d_q;
    assign bus.b    = b_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized and directed bench for serial_subtractor (WIDTH=8) against an
// arithmetic reference: d = (x - y) mod 256, b = (x < y).
module tb_serial_subtractor;

    localparam int unsigned WIDTH = 8;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    logic [WIDTH-1:0] last_d;
    logic             last_b;

    serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if it disagrees.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model for one operation.
    function automatic logic [WIDTH:0] ref_sub(input logic [WIDTH-1:0] xv, input logic [WIDTH-1:0] yv);
        int unsigned diff;
        diff = (int'(xv) - int'(yv) + 256) % 256;
        return {(xv < yv), WIDTH'(diff)};
    endfunction

    // One pulsed operation; optional noise on inputs while it runs.
    task automatic run_op(input logic [WIDTH-1:0] xv, input logic [WIDTH-1:0] yv, input bit noise);
        int busy_cycles;
        int guard;
        logic [WIDTH:0] exp;
        exp = ref_sub(xv, yv);
        @(negedge clk);
        bus.start = 1'b1;
        bus.x     = xv;
        bus.y     = yv;
        @(negedge clk);
        bus.start = 1'b0;
        busy_cycles = 0;
        guard = 0;
        while (!bus.done && guard < 100) begin
            if (bus.busy) busy_cycles++;
            if (bus.d !== last_d || bus.b !== last_b)
                check("hold_d", {23'd0, bus.b, bus.d}, {23'd0, last_b, last_d});
            if (noise) begin
                bus.start = 1'($urandom);
                bus.x     = WIDTH'($urandom);
                bus.y     = WIDTH'($urandom);
            end
            guard++;
            @(negedge clk);
        end
        bus.start = 1'b0;
        check("done_seen", 32'(guard < 100), 32'd1);
        check("latency", 32'(busy_cycles), 32'(WIDTH));
        check("d", 32'(bus.d), 32'(exp[WIDTH-1:0]));
        check("b", 32'(bus.b), 32'(exp[WIDTH]));
        check("busy_in_done", 32'(bus.busy), 32'd0);
        last_d = exp[WIDTH-1:0];
        last_b = exp[WIDTH];
        @(negedge clk);
        check("done_pulse", 32'(bus.done), 32'd0);
    endtask

    // Wait until the block is quiescent, bounded.
    task automatic wait_idle();
        int guard;
        guard = 0;
        while ((bus.busy || bus.done) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("idle_reached", 32'(guard < 100), 32'd1);
    endtask

    initial begin
        int done_cnt;
        int last_done;
        int gap_bad;
        int guard;
        n_checks  = 0;
        n_fail    = 0;
        last_d    = '0;
        last_b    = 1'b0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.x     = '0;
        bus.y     = '0;

        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_d", 32'(bus.d), 32'd0);
        check("rst_b", 32'(bus.b), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors.
        run_op(8'h05, 8'h03, 1'b0);
        run_op(8'h03, 8'h05, 1'b0);
        run_op(8'h00, 8'hFF, 1'b0);
        run_op(8'hFF, 8'hFF, 1'b0);

        // Start during RUN is ignored.
        @(negedge clk);
        bus.start = 1'b1; bus.x = 8'h10; bus.y = 8'h01;
        @(negedge clk);
        bus.start = 1'b0; bus.x = '0; bus.y = '0;
        repeat (2) @(negedge clk);
        bus.start = 1'b1; bus.x = 8'hAA; bus.y = 8'h55;
        @(negedge clk);
        bus.start = 1'b0;
        guard = 0;
        while (!bus.done && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("ign_done_seen", 32'(guard < 100), 32'd1);
        check("ign_d", 32'(bus.d), 32'h0F);
        check("ign_b", 32'(bus.b), 32'd0);
        done_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) done_cnt++;
        end
        check("ign_single_done", 32'(done_cnt), 32'd0);
        last_d = 8'h0F; last_b = 1'b0;

        // Start held high: back-to-back with a 9-cycle period.
        @(negedge clk);
        bus.start = 1'b1; bus.x = 8'h80; bus.y = 8'h01;
        done_cnt = 0; last_done = -1; gap_bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.busy === bus.done) gap_bad++;
            if (bus.done) begin
                if (last_done >= 0 && (i - last_done) != 9) gap_bad++;
                if (bus.d !== 8'h7F || bus.b !== 1'b0) gap_bad++;
                last_done = i;
                done_cnt++;
            end
        end
        bus.start = 1'b0;
        check("b2b_errors", 32'(gap_bad), 32'd0);
        check("b2b_done_count", 32'(done_cnt), 32'd5);
        wait_idle();
        last_d = 8'h7F; last_b = 1'b0;

        // Asynchronous reset mid-RUN.
        @(negedge clk);
        bus.start = 1'b1; bus.x = 8'h03; bus.y = 8'h05;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(bus.busy), 32'd0);
        check("arst_done", 32'(bus.done), 32'd0);
        check("arst_d", 32'(bus.d), 32'd0);
        check("arst_b", 32'(bus.b), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) done_cnt++;
        end
        check("arst_no_done", 32'(done_cnt), 32'd0);
        last_d = '0; last_b = 1'b0;
        run_op(8'h09, 8'h04, 1'b0);

        // Random operations with input noise while running.
        for (int i = 0; i < 1000; i++)
            run_op(WIDTH'($urandom), WIDTH'($urandom), 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
